// File: rtl/cpu_memory_responder.sv
// -----------------------------------------------------------------------------
// cpu_memory_responder
//
// Memory-side end of the CPU memory interface. A 2**ADDR_WIDTH x DATA_WIDTH
// register-file RAM answers CPU read/write/address/memoryIn requests on
// memoryOut with zero read latency. A byte-wide loader with a valid/ready
// handshake fills the RAM from LOAD_BASE upwards while the CPU is held in
// reset, then releases the CPU.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-high reset (clears state and memory)
//   read         CPU read strobe (output is not gated by it)
//   write        CPU write strobe
//   address      CPU address
//   memoryIn     CPU write data
//   memoryOut    CPU read data, mem[address] in RUN, 0 otherwise
//   load_start   begin (or restart) a program load
//   load_valid   load_data holds a byte to store
//   load_data    program byte
//   load_last    marks the final program byte
//   load_ready   a loader byte is accepted this cycle (LOAD state)
//   load_done    one-cycle pulse on the first RUN cycle after a load
//   cpu_reset    reset for the CPU, high whenever the CPU must not run
//   write_fault  sticky flag: a CPU write was blocked by the write guard
//
// Build option:
//   MEM_WRITE_GUARD_EN  when defined, CPU writes to addresses below
//                       GUARD_LIMIT are suppressed and raise write_fault.
//                       When undefined, all CPU writes are honoured and
//                       write_fault is tied low.
// -----------------------------------------------------------------------------
module cpu_memory_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int LOAD_BASE   = 1,
    parameter int GUARD_LIMIT = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] memoryIn,
    output logic [DATA_WIDTH-1:0] memoryOut,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  cpu_reset,
    output logic                  write_fault
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_BASE = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_load_done;
    logic                  r_write_fault;

    logic                  w_load_ready;
    logic                  w_cpu_reset;
    logic                  w_xfer;
    logic                  w_finish;
    logic                  w_cpu_wr;
    logic                  w_guard_hit;

    // The read strobe is part of the CPU interface but the RAM output is
    // always driven from the address, so the strobe carries no information.
    logic                  w_unused_read;
    assign w_unused_read = read;

    assign w_guard_hit = (int'(address) < GUARD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_cpu_reset  = 1'b1;
        w_xfer       = 1'b0;
        w_finish     = 1'b0;
        w_cpu_wr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load_ready = 1'b1;
                w_xfer       = load_valid;
                // The top address ends the load even without load_last so
                // the pointer never wraps back onto address 0.
                w_finish     = w_xfer && (load_last || (r_ptr == PTR_MAX));
                if (load_start) begin
                    w_state_nxt = S_LOAD;
                end else if (w_finish) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A reload request pulls the CPU back into reset at once and
                // its write in that same cycle is discarded.
                w_cpu_reset = load_start;
                if (load_start) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cpu_wr = write;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr         <= PTR_BASE;
            r_load_done   <= 1'b0;
            r_write_fault <= 1'b0;
        end else begin
            r_load_done <= (r_state == S_LOAD) && (w_state_nxt == S_RUN);

            if (w_xfer) begin
                r_mem[r_ptr] <= load_data;
            end

            // Every state enters LOAD on load_start with a fresh pointer.
            if (load_start) begin
                r_ptr <= PTR_BASE;
            end else if (w_xfer && (r_ptr != PTR_MAX)) begin
                r_ptr <= r_ptr + 1'b1;
            end

`ifdef MEM_WRITE_GUARD_EN
            if (w_cpu_wr) begin
                if (w_guard_hit) begin
                    r_write_fault <= 1'b1;
                end else begin
                    r_mem[address] <= memoryIn;
                end
            end
`else
            if (w_cpu_wr) begin
                r_mem[address] <= memoryIn;
            end
`endif
        end
    end

`ifndef MEM_WRITE_GUARD_EN
    logic w_unused_guard;
    assign w_unused_guard = w_guard_hit;
`endif

    assign memoryOut   = (r_state == S_RUN) ? r_mem[address] : '0;
    assign load_ready  = w_load_ready;
    assign load_done   = r_load_done;
    assign cpu_reset   = w_cpu_reset;
    assign write_fault = r_write_fault;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_memory_responder
//
// Self-checking bench for cpu_memory_responder. Read expectations come from a
// bench-side memory model, are pushed to a scoreboard queue when a read
// address is driven, and are popped and compared against memoryOut.
// Expectations for the write guard follow MEM_WRITE_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_cpu_memory_responder;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int BASE = 1;

    typedef logic [DW-1:0] byte_q_t[$];

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } sb_entry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] memoryIn;
    logic [DW-1:0] memoryOut;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic          cpu_reset;
    logic          write_fault;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] model [16];
    sb_entry_t     sb_q[$];

    cpu_memory_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LOAD_BASE  (BASE),
        .GUARD_LIMIT(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .memoryIn   (memoryIn),
        .memoryOut  (memoryOut),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .cpu_reset  (cpu_reset),
        .write_fault(write_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    // Drive a read address, push the expected word, compare at the falling edge.
    task automatic rd(input string tag, input int addr);
        sb_entry_t e;
        address = AW'(addr);
        e.tag = tag;
        e.exp = model[addr];
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, {24'd0, memoryOut}, {24'd0, e.exp});
        end
        step();
    endtask

    // Full load: load_start pulse, bytes with optional idle-valid gaps, then
    // checks ready-cycle count, the single load_done pulse and cpu_reset release.
    task automatic do_load(input string tag, input byte_q_t bytes, input bit gaps,
                           input bit use_last);
        int ptr = BASE;
        int ready_cnt = 0;
        int done_cnt = 0;
        int exp_ready;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        write      = 1'b0;
        for (int i = 0; i < bytes.size(); i++) begin
            if (gaps && i > 0) begin
                load_valid = 1'b0;
                load_data  = 8'hEE;
                @(negedge clk);
                if (load_ready) ready_cnt++;
                if (load_done) done_cnt++;
                step();
            end
            load_valid = 1'b1;
            load_data  = bytes[i];
            load_last  = use_last && (i == bytes.size() - 1);
            @(negedge clk);
            if (load_ready) ready_cnt++;
            if (load_done) done_cnt++;
            model[ptr] = bytes[i];
            ptr++;
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, load_done}, 32'd1);
        chk({tag, "_cpu_reset_low"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, "_ready_low"}, {31'd0, load_ready}, 32'd0);
        if (load_done) done_cnt++;
        step();
        @(negedge clk);
        if (load_done) done_cnt++;
        step();
        exp_ready = gaps ? 2 * bytes.size() - 1 : bytes.size();
        chk({tag, "_ready_cycles"}, ready_cnt, exp_ready);
        chk({tag, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        byte_q_t prog;
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        memoryIn   = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        clear_model();
        step();
        step();
        @(negedge clk);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_write_fault", {31'd0, write_fault}, 32'd0);
        chk("rst_memoryOut", {24'd0, memoryOut}, 32'd0);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        step();

        // Program load, valid every cycle.
        prog = '{8'h36, 8'h56, 8'h06, 8'h00, 8'h0A, 8'h05};
        do_load("ld6", prog, 1'b0, 1'b1);
        chk("ld6_model6", {24'd0, model[6]}, 32'h05);
        rd("rd_a6", 6);
        rd("rd_a1", 1);
        rd("rd_a0", 0);

        // CPU write at address 6: old value same cycle, new value next cycle.
        read = 1'b1; write = 1'b1; memoryIn = 8'h02;
        rd("wr6_same_cycle", 6);
        write = 1'b0;
        model[6] = 8'h02;
        rd("wr6_next_cycle", 6);
        @(negedge clk);
        chk("wr6_fault", {31'd0, write_fault}, 32'd0);
        step();

        // CPU write into the guarded region.
        write = 1'b1; memoryIn = 8'hFF;
        rd("wr2_same_cycle", 2);
        write = 1'b0;
`ifdef MEM_WRITE_GUARD_EN
        rd("wr2_blocked", 2);
        @(negedge clk);
        chk("wr2_fault_set", {31'd0, write_fault}, 32'd1);
        step();
        @(negedge clk);
        chk("wr2_fault_held", {31'd0, write_fault}, 32'd1);
        step();
`else
        model[2] = 8'hFF;
        rd("wr2_written", 2);
        @(negedge clk);
        chk("wr2_no_fault", {31'd0, write_fault}, 32'd0);
        step();
`endif

        // Reload with a write in the load_start cycle (dropped) and gapped valid.
        write = 1'b1; address = 4'd7; memoryIn = 8'hAA;
        prog = '{8'h11, 8'h22, 8'h33};
        do_load("ldgap", prog, 1'b1, 1'b1);
        rd("gap_a1", 1);
        rd("gap_a2", 2);
        rd("gap_a3", 3);
        rd("gap_a4_kept", 4);
        rd("gap_a6_kept", 6);
        rd("drop_wr_a7", 7);

        // 15 bytes without load_last: terminal address ends the load.
        prog = {};
        for (int i = 0; i < 15; i++) prog.push_back(8'h40 + DW'(i));
        do_load("ld15", prog, 1'b0, 1'b0);
        load_valid = 1'b1; load_data = 8'h99;
        @(negedge clk);
        chk("ld16_not_ready", {31'd0, load_ready}, 32'd0);
        step();
        load_valid = 1'b0;
        rd("ld15_a0", 0);
        rd("ld15_a1", 1);
        rd("ld15_a15", 15);

        // Reset after 3 of 6 bytes, then a fresh one-byte load.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 8'hC0 + DW'(i);
            step();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("midrst_ready", {31'd0, load_ready}, 32'd0);
        chk("midrst_memoryOut", {24'd0, memoryOut}, 32'd0);
        chk("midrst_fault", {31'd0, write_fault}, 32'd0);
        step();
        prog = '{8'h77};
        do_load("ld1", prog, 1'b0, 1'b1);
        for (int a = 0; a < 16; a++) rd($sformatf("post_rst_a%0d", a), a);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
